// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants, history type and length clamp for the pattern detector
package seq_det_pkg;
    localparam int MAX_LEN = 8;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_W = 8;
    typedef logic [MAX_LEN-1:0] hist_t;
    localparam hist_t DEF_PAT = 8'b00001011;
    localparam int DEF_LEN = 4;

    function automatic int clamp_len(input int l, input int max_len);
        return (l < 1) ? 1 : ((l > max_len) ? max_len : l);
    endfunction
endpackage

// File: rtl/seq_det_if.sv
// seq_det_if: serial input, configuration and match-status bundle of the pattern detector
interface seq_det_if #(
    parameter int MAX_LEN = seq_det_pkg::MAX_LEN,
    parameter int LEN_W = seq_det_pkg::LEN_W,
    parameter int CNT_W = seq_det_pkg::CNT_W
);
    logic               x;
    logic               x_vld;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               overlap;
    logic               lock_en;
    logic               clr;
    logic               z;
    logic               locked;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output x, x_vld, cfg_we, cfg_pat, cfg_len, overlap, lock_en, clr,
        input  z, locked, match_cnt
    );
    modport slave (
        input  x, x_vld, cfg_we, cfg_pat, cfg_len, overlap, lock_en, clr,
        output z, locked, match_cnt
    );
endinterface

// File: rtl/seq_det_match.sv
// seq_det_match: masked compare of the next history against the low len bits of the pattern
module seq_det_match #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W = 4
) (
    input  logic [MAX_LEN-1:0] hist_next,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic [LEN_W-1:0]   fill,
    output logic               hit
);
    import seq_det_pkg::*;

    logic [MAX_LEN-1:0] mask;

    // ones in the low len positions; len == MAX_LEN shifts everything out, giving all ones
    always_comb mask = ~({MAX_LEN{1'b1}} << len);

    assign hit = (({1'b0, fill} + 1'b1) >= {1'b0, len}) && (((hist_next ^ pat) & mask) == '0);
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: runtime-loadable serial pattern detector; SEQ_DET_MEALY_OUT_EN selects a combinational z
module seq_pattern_detector #(
    parameter int MAX_LEN = seq_det_pkg::MAX_LEN,
    parameter int LEN_W = $clog2(MAX_LEN + 1),
    parameter int CNT_W = seq_det_pkg::CNT_W,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(seq_det_pkg::DEF_PAT),
    parameter int DEF_LEN = seq_det_pkg::DEF_LEN
) (
    input logic      clk,
    input logic      rst_n,
    seq_det_if.slave bus
);
    import seq_det_pkg::*;

    logic [MAX_LEN-1:0] pat, hist, hist_next;
    logic [LEN_W-1:0]   len, fill, fill_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               locked, hit_raw, hit;

    assign hist_next = {hist[MAX_LEN-2:0], bus.x};
    assign fill_nxt = (fill == len) ? len : fill + 1'b1;

    seq_det_match #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_match (
        .hist_next(hist_next),
        .pat(pat),
        .len(len),
        .fill(fill),
        .hit(hit_raw)
    );

    // a hit only counts on a real sample: valid bit, unlocked, no config load or clear this edge
    assign hit = hit_raw & bus.x_vld & ~locked & ~bus.cfg_we & ~bus.clr;

    // state update with priority cfg_we > clr > sample; cfg_we together with clr also clears the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat    <= DEF_PAT;
            len    <= LEN_W'(DEF_LEN);
            hist   <= '0;
            fill   <= '0;
            locked <= 1'b0;
            cnt    <= '0;
        end else if (bus.cfg_we) begin
            pat    <= bus.cfg_pat;
            len    <= LEN_W'(clamp_len(int'(bus.cfg_len), MAX_LEN));
            hist   <= '0;
            fill   <= '0;
            locked <= 1'b0;
            if (bus.clr) cnt <= '0;
        end else if (bus.clr) begin
            hist   <= '0;
            fill   <= '0;
            locked <= 1'b0;
            cnt    <= '0;
        end else if (bus.x_vld && !locked) begin
            hist <= hist_next;
            fill <= (hit && !bus.overlap) ? '0 : fill_nxt;
            if (hit && !(&cnt)) cnt <= cnt + 1'b1;
            if (hit && bus.lock_en) locked <= 1'b1;
        end
    end

`ifdef SEQ_DET_MEALY_OUT_EN
    assign bus.z = hit | locked;
`else
    logic z_q;

    // registered match flag, held high while the detector sits in the lock state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) z_q <= 1'b0;
        else        z_q <= hit | (locked & ~bus.cfg_we & ~bus.clr);
    end

    assign bus.z = z_q;
`endif

    assign bus.locked = locked;
    assign bus.match_cnt = cnt;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed checks of the pattern detector in its default registered-output build
module tb_seq_pattern_detector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_det_if bus ();

    seq_pattern_detector dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic vx, input logic vv);
        bus.x = vx;
        bus.x_vld = vv;
        @(posedge clk);
        #1;
        bus.x = 1'b0;
        bus.x_vld = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l);
        bus.cfg_we = 1'b1;
        bus.cfg_pat = p;
        bus.cfg_len = l;
        cyc(1'b0, 1'b0);
        bus.cfg_we = 1'b0;
    endtask

    task automatic clr_pulse();
        bus.clr = 1'b1;
        cyc(1'b0, 1'b0);
        bus.clr = 1'b0;
    endtask

    initial begin
        logic [7:0] p8;
        bus.x = 1'b0;
        bus.x_vld = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_pat = '0;
        bus.cfg_len = '0;
        bus.overlap = 1'b1;
        bus.lock_en = 1'b0;
        bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_z", 32'(bus.z), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_cnt", 32'(bus.match_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        cyc(0, 1); cyc(1, 1); cyc(0, 1); cyc(1, 1);
        check("def_4bits_z", 32'(bus.z), 0);
        cyc(1, 1);
        check("def_hit_z", 32'(bus.z), 1);
        check("def_hit_cnt", 32'(bus.match_cnt), 1);
        cyc(0, 0);
        check("def_z_drop", 32'(bus.z), 0);

        clr_pulse();
        cfg(8'b11, 4'd2);
        cyc(1, 1);
        check("ov_bit1_z", 32'(bus.z), 0);
        cyc(1, 1);
        check("ov_bit2_z", 32'(bus.z), 1);
        cyc(1, 1);
        check("ov_bit3_z", 32'(bus.z), 1);
        cyc(1, 1);
        check("ov_bit4_z", 32'(bus.z), 1);
        check("ov_cnt", 32'(bus.match_cnt), 3);

        clr_pulse();
        bus.overlap = 1'b0;
        cfg(8'b11, 4'd2);
        cyc(1, 1); cyc(1, 1); cyc(1, 1);
        check("nov_bit3_z", 32'(bus.z), 0);
        cyc(1, 1);
        check("nov_bit4_z", 32'(bus.z), 1);
        check("nov_cnt", 32'(bus.match_cnt), 2);
        bus.overlap = 1'b1;

        clr_pulse();
        bus.lock_en = 1'b1;
        cfg(8'b101, 4'd3);
        cyc(1, 1); cyc(0, 1); cyc(1, 1); cyc(0, 1); cyc(0, 1);
        check("lock_locked", 32'(bus.locked), 1);
        check("lock_z", 32'(bus.z), 1);
        check("lock_cnt", 32'(bus.match_cnt), 1);
        cyc(1, 1); cyc(0, 1); cyc(1, 1);
        check("lock_frozen_cnt", 32'(bus.match_cnt), 1);
        clr_pulse();
        check("unlock_locked", 32'(bus.locked), 0);
        check("unlock_z", 32'(bus.z), 0);
        check("unlock_cnt", 32'(bus.match_cnt), 0);
        bus.lock_en = 1'b0;

        cfg(8'b1, 4'd0);
        cyc(1, 1);
        check("len0_hit1", 32'(bus.z), 1);
        cyc(0, 1);
        check("len0_miss", 32'(bus.z), 0);
        cyc(1, 1);
        check("len0_hit2", 32'(bus.z), 1);
        check("len0_cnt", 32'(bus.match_cnt), 2);
        clr_pulse();
        repeat (260) cyc(1, 1);
        check("sat_cnt", 32'(bus.match_cnt), 255);
        check("sat_z", 32'(bus.z), 1);

        p8 = 8'hB3;
        cfg(p8, 4'd15);
        for (int i = 7; i >= 1; i--) cyc(p8[i], 1);
        check("len15_7bits_z", 32'(bus.z), 0);
        cyc(p8[0], 1);
        check("len15_8bits_z", 32'(bus.z), 1);

        clr_pulse();
        cfg(8'b1011, 4'd4);
        cyc(1, 1); cyc(0, 1); cyc(1, 1); cyc(1, 1);
        check("pre_rst_cnt", 32'(bus.match_cnt), 1);
        cyc(1, 1); cyc(0, 1); cyc(1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_cnt", 32'(bus.match_cnt), 0);
        check("async_rst_z", 32'(bus.z), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1);
        check("post_rst_lone1", 32'(bus.z), 0);
        cyc(0, 1); cyc(1, 1); cyc(1, 1);
        check("post_rst_hit", 32'(bus.z), 1);

        clr_pulse();
        cyc(1, 1);
        cyc(1, 0);
        check("gap_z", 32'(bus.z), 0);
        cyc(0, 1);
        cyc(0, 0);
        cyc(1, 1);
        cyc(1, 1);
        check("gap_hit_z", 32'(bus.z), 1);
        check("gap_cnt", 32'(bus.match_cnt), 1);

        bus.x = 1'b1;
        bus.x_vld = 1'b1;
        bus.cfg_we = 1'b1;
        bus.cfg_pat = 8'b11;
        bus.cfg_len = 4'd2;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        bus.x_vld = 1'b0;
        check("cfg_keeps_cnt", 32'(bus.match_cnt), 1);
        cyc(1, 1);
        check("cfg_drops_bit", 32'(bus.z), 0);
        bus.cfg_we = 1'b1;
        bus.clr = 1'b1;
        cyc(0, 0);
        bus.cfg_we = 1'b0;
        bus.clr = 1'b0;
        check("cfg_clr_cnt", 32'(bus.match_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
